// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle reader.
// Holds FSM state enum, raw-count type and the paddle mapping helper.
package paddle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDischarge,
    StCharge,
    StPublish
  } paddle_reader_state_t;

  localparam int unsigned PaddleOutMin = 30;
  localparam int unsigned PaddleOutMax = 220;

  typedef logic [9:0] paddle_raw_t;

  // 11-bit sum so OutMin + a full 10-bit raw cannot wrap before the clamp.
  function automatic logic [7:0] paddle_map(
    input paddle_raw_t raw,
    input int unsigned out_min,
    input int unsigned out_max
  );
    logic [10:0] sum;
    sum = 11'(out_min) + 11'(raw);
    if (sum > 11'(out_max)) begin
      sum = 11'(out_max);
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces one active-low button.
// Ports: clk, reset (async high), in_n (raw button), pressed (1 = pressed).
module button_debounce #(
  parameter int unsigned DebounceBits = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_n,
  output logic pressed
);

  logic                    s1_q;
  logic                    s2_q;
  logic                    pressed_q;
  logic [DebounceBits-1:0] cnt_q;
  logic                    level;

  assign level   = ~s2_q;
  assign pressed = pressed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= in_n;
      s2_q <= s1_q;
    end
  end

  // Output flips only after a full counter run of disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else if (level == pressed_q) begin
      cnt_q <= '0;
    end else if (&cnt_q) begin
      pressed_q <= level;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + DebounceBits'(1);
    end
  end

endmodule

// File: rtl/paddle_reader.sv
// Dual RC paddle timer: discharge, time recharge, map, publish; plus buttons.
// Ports: clk, reset, newframe, pot_charged[1:0], button_n[1:0] in;
//        pot_discharge, paddle0/1[7:0], paddle0/1_button, valid out.
module paddle_reader
  import paddle_pkg::*;
#(
  parameter int unsigned DischargeCycles = 2048,
  parameter int unsigned CountShift      = 6,
  parameter int unsigned CountMax        = 190,
  parameter int unsigned OutMin          = PaddleOutMin,
  parameter int unsigned OutMax          = PaddleOutMax,
  parameter int unsigned DebounceBits    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       newframe,
  input  logic [1:0] pot_charged,
  input  logic [1:0] button_n,
  output logic       pot_discharge,
  output logic [7:0] paddle0,
  output logic [7:0] paddle1,
  output logic       paddle0_button,
  output logic       paddle1_button,
  output logic       valid
);

  localparam int unsigned DcW = $clog2(DischargeCycles) + 1;
  localparam int unsigned PsW = (CountShift > 0) ? CountShift : 1;
  localparam logic [DcW-1:0] DcLast = DcW'(DischargeCycles - 1);
  // With CountShift = 0 this is 0 and the prescaler wraps every cycle.
  localparam logic [PsW-1:0] PsLast = PsW'((1 << CountShift) - 1);
  localparam paddle_raw_t RawMax = paddle_raw_t'(CountMax);
  localparam logic [7:0] PaddleRst = 8'((OutMin + OutMax) / 2);

  logic [1:0]           pc_s1_q;
  logic [1:0]           pc_s2_q;
  paddle_reader_state_t state_q;
  logic [DcW-1:0]       dcnt_q;
  logic [PsW-1:0]       ps_q;
  paddle_raw_t          tick_q;
  logic [1:0]           done_q;
  paddle_raw_t          raw0_q;
  paddle_raw_t          raw1_q;
  logic                 pot_discharge_q;
  logic                 valid_q;
  logic [7:0]           paddle0_q;
  logic [7:0]           paddle1_q;

  logic        ps_wrap;
  logic [1:0]  cap;
  logic [1:0]  done_d;
  paddle_raw_t raw0_d;
  paddle_raw_t raw1_d;
  paddle_raw_t fin0;
  paddle_raw_t fin1;
  logic        exit_charge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_s1_q <= '0;
      pc_s2_q <= '0;
    end else begin
      pc_s1_q <= pot_charged;
      pc_s2_q <= pc_s1_q;
    end
  end

  // Capture and exit decisions for the current CHARGE cycle.
  always_comb begin
    ps_wrap     = (ps_q == PsLast);
    cap         = pc_s2_q & ~done_q;
    done_d      = done_q | cap;
    raw0_d      = cap[0] ? tick_q : raw0_q;
    raw1_d      = cap[1] ? tick_q : raw1_q;
    fin0        = done_d[0] ? raw0_d : RawMax;
    fin1        = done_d[1] ? raw1_d : RawMax;
    exit_charge = (&done_d) || (tick_q == RawMax);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      dcnt_q          <= '0;
      ps_q            <= '0;
      tick_q          <= '0;
      done_q          <= '0;
      raw0_q          <= '0;
      raw1_q          <= '0;
      pot_discharge_q <= 1'b1;
      valid_q         <= 1'b0;
      paddle0_q       <= PaddleRst;
      paddle1_q       <= PaddleRst;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (newframe) begin
            state_q <= StDischarge;
            dcnt_q  <= '0;
          end
        end
        StDischarge: begin
          if (dcnt_q == DcLast) begin
            state_q         <= StCharge;
            pot_discharge_q <= 1'b0;
            ps_q            <= '0;
            tick_q          <= '0;
            done_q          <= '0;
          end else begin
            dcnt_q <= dcnt_q + DcW'(1);
          end
        end
        StCharge: begin
          ps_q   <= ps_wrap ? '0 : ps_q + PsW'(1);
          done_q <= done_d;
          raw0_q <= fin0;
          raw1_q <= fin1;
          if (ps_wrap) begin
            tick_q <= tick_q + 10'd1;
          end
          // Results land with PUBLISH so valid and paddles align.
          if (exit_charge) begin
            state_q         <= StPublish;
            pot_discharge_q <= 1'b1;
            valid_q         <= 1'b1;
            paddle0_q <= paddle_map(fin0, OutMin, OutMax);
            paddle1_q <= paddle_map(fin1, OutMin, OutMax);
          end
        end
        StPublish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pot_discharge = pot_discharge_q;
  assign valid         = valid_q;
  assign paddle0       = paddle0_q;
  assign paddle1       = paddle1_q;

  button_debounce #(
    .DebounceBits(DebounceBits)
  ) u_btn0 (
    .clk    (clk),
    .reset  (reset),
    .in_n   (button_n[0]),
    .pressed(paddle0_button)
  );

  button_debounce #(
    .DebounceBits(DebounceBits)
  ) u_btn1 (
    .clk    (clk),
    .reset  (reset),
    .in_n   (button_n[1]),
    .pressed(paddle1_button)
  );

endmodule

// File: tb/tb_paddle_reader.sv
// Directed bench for paddle_reader with short timing parameters.
// Second instance uses OutMin=210 to exercise the clamp.
module tb_paddle_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       newframe;
  logic [1:0] pot_charged;
  logic [1:0] button_n;

  logic       pd;
  logic [7:0] p0;
  logic [7:0] p1;
  logic       b0;
  logic       b1;
  logic       vld;

  logic       pd2;
  logic [7:0] q0;
  logic [7:0] q1;
  logic       c0;
  logic       c1;
  logic       vld2;

  int cyc = 0;
  int nvalid = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld === 1'b1) nvalid++;
  end

  paddle_reader #(
    .DischargeCycles(4),
    .CountShift     (0),
    .CountMax       (15),
    .DebounceBits   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .newframe      (newframe),
    .pot_charged   (pot_charged),
    .button_n      (button_n),
    .pot_discharge (pd),
    .paddle0       (p0),
    .paddle1       (p1),
    .paddle0_button(b0),
    .paddle1_button(b1),
    .valid         (vld)
  );

  paddle_reader #(
    .DischargeCycles(4),
    .CountShift     (0),
    .CountMax       (15),
    .OutMin         (210),
    .DebounceBits   (3)
  ) dut2 (
    .clk           (clk),
    .reset         (reset),
    .newframe      (newframe),
    .pot_charged   (pot_charged),
    .button_n      (button_n),
    .pot_discharge (pd2),
    .paddle0       (q0),
    .paddle1       (q1),
    .paddle0_button(c0),
    .paddle1_button(c1),
    .valid         (vld2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Returns #1 after clock edge n.
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset       = 1'b1;
    newframe    = 1'b0;
    pot_charged = 2'b00;
    button_n    = 2'b11;
    #1;
    chk("rst_p0", 32'(p0), 125);
    chk("rst_p1", 32'(p1), 125);
    chk("rst_pd", 32'(pd), 1);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_b1", 32'(b1), 0);
    chk("rst_q0", 32'(q0), 215);
    at(3);
    reset = 1'b0;

    // Measurement: charge seen at cycle 20, synced at 22 -> tick 7.
    at(10);
    chk("idle_pd", 32'(pd), 1);
    chk("idle_vld", 32'(vld), 0);
    newframe = 1'b1;
    at(11);
    newframe = 1'b0;
    at(14);
    chk("dis_pd", 32'(pd), 1);
    at(15);
    chk("chg_pd", 32'(pd), 0);
    at(20);
    pot_charged = 2'b11;
    at(22);
    chk("pre_vld", 32'(vld), 0);
    at(23);
    chk("m1_vld", 32'(vld), 1);
    chk("m1_p0", 32'(p0), 37);
    chk("m1_p1", 32'(p1), 37);
    chk("m1_q0", 32'(q0), 217);
    at(24);
    chk("m1_vld_end", 32'(vld), 0);
    chk("m1_pd", 32'(pd), 1);
    chk("m1_nvalid", 32'(nvalid), 1);
    pot_charged = 2'b00;

    // Timeout with extra newframes in DISCHARGE and CHARGE.
    at(30);
    newframe = 1'b1;
    at(31);
    newframe = 1'b0;
    at(32);
    newframe = 1'b1;
    at(33);
    newframe = 1'b0;
    at(34);
    chk("m2_dis_pd", 32'(pd), 1);
    at(35);
    chk("m2_chg_pd", 32'(pd), 0);
    at(36);
    pot_charged = 2'b01;
    at(40);
    newframe = 1'b1;
    at(41);
    newframe = 1'b0;
    at(50);
    chk("m2_pre_vld", 32'(vld), 0);
    at(51);
    chk("m2_vld", 32'(vld), 1);
    chk("m2_p0", 32'(p0), 33);
    chk("m2_p1", 32'(p1), 45);
    chk("clamp_q0", 32'(q0), 213);
    chk("clamp_q1", 32'(q1), 220);
    at(52);
    pot_charged = 2'b00;
    at(60);
    chk("m2_noqueue_pd", 32'(pd), 1);
    chk("m2_nvalid", 32'(nvalid), 2);

    // Reset asserted mid-CHARGE after a partial capture.
    at(70);
    newframe = 1'b1;
    at(71);
    newframe = 1'b0;
    at(75);
    pot_charged = 2'b01;
    at(78);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_p0", 32'(p0), 125);
    chk("mid_rst_p1", 32'(p1), 125);
    chk("mid_rst_pd", 32'(pd), 1);
    chk("mid_rst_vld", 32'(vld), 0);
    chk("mid_rst_q1", 32'(q1), 215);
    at(80);
    reset = 1'b0;
    pot_charged = 2'b00;
    at(100);
    chk("post_rst_nvalid", 32'(nvalid), 2);
    chk("post_rst_pd", 32'(pd), 1);
    chk("post_rst_p0", 32'(p0), 125);

    // Button 1: three 6-cycle bounces, then a hold, then release.
    for (int k = 0; k < 3; k++) begin
      at(110 + 8 * k);
      button_n[1] = 1'b0;
      at(116 + 8 * k);
      button_n[1] = 1'b1;
      chk("bounce_b1", 32'(b1), 0);
    end
    at(134);
    chk("bounce_end_b1", 32'(b1), 0);
    at(140);
    button_n[1] = 1'b0;
    at(149);
    chk("hold_early_b1", 32'(b1), 0);
    at(150);
    chk("hold_b1", 32'(b1), 1);
    chk("hold_b0", 32'(b0), 0);
    at(160);
    button_n[1] = 1'b1;
    at(169);
    chk("rel_early_b1", 32'(b1), 1);
    at(170);
    chk("rel_b1", 32'(b1), 0);

    at(175);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
